key_queue: RTL and testbench
============================

# key_queue

Parametrised keypoint queue between the feature detector and the matching stage. Stores up to DEPTH keypoint records (x/y coordinate plus orientation sin/cos) in a circular buffer. Records are delivered in arrival order over valid/ready handshakes on both sides, with full/empty/occupancy status and synchronous flush. An optional compile-time mode overwrites the oldest record when the queue is full instead of back-pressuring.

## Interface
- DEPTH, 100, number of records; legal range 2..1023, any value (not restricted to powers of two)
- CW, 10, coordinate field width
- TW, 12, sin/cos field width (two's complement, passed through unmodified)
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock, asynchronous assert, active-high
- i_flush  in  1  synchronous clear of queue contents
- i_push_valid  in  1  input record valid
- o_push_ready  out  1  queue accepts a record this cycle
- i_coor_x, i_coor_y  in  CW  input coordinates
- i_sin, i_cos  in  TW  input orientation
- o_pop_valid  out  1  head record valid
- i_pop_ready  in  1  consumer takes head record
- o_coor_x, o_coor_y  out  CW  head coordinates
- o_sin, o_cos  out  TW  head orientation
- o_count  out  $clog2(DEPTH+1)  current occupancy
- o_full, o_empty  out  1  count==DEPTH / count==0
- o_drop  out  1  one-cycle pulse: a record was overwritten (replace mode only)
- o_drop_cnt  out  16  saturating count of overwritten records

## Operation
- Storage: DEPTH-entry memory; wr_ptr, rd_ptr in 0..DEPTH-1; both wrap from DEPTH-1 to 0; count register 0..DEPTH.
- Push fires when i_push_valid && o_push_ready: record written at wr_ptr; wr_ptr advances.
- Pop fires when o_pop_valid && i_pop_ready: rd_ptr advances.
- o_pop_valid = !o_empty. Head data outputs are first-word fall-through from memory[rd_ptr]. All four data outputs are forced to 0 while o_pop_valid is low.
- Count update: +1 on push only; −1 on pop only; unchanged on both or neither.
- Empty with push and pop requested: push fires, pop does not; count becomes 1.
- Full with push and pop in the same cycle: see Configuration.
- Flush: highest priority over push and pop in the same cycle. Clears wr_ptr, rd_ptr and count. Memory contents and o_drop_cnt are not cleared. o_drop is driven to 0 in the following cycle.
- Reset: all pointers, count and o_drop_cnt are 0. Memory is not required to be cleared, because outputs are masked. Reset during any operation aborts that operation immediately.

## Timing
- Reset values: o_push_ready=1, o_pop_valid=0, o_empty=1, o_full=0, o_count=0, data outputs=0, o_drop=0, o_drop_cnt=0.
- Push-to-pop latency: a record pushed at edge N is visible at the head (o_pop_valid=1) after edge N, i.e. in cycle N+1, if the queue was empty.
- o_count, o_full and o_empty are registered-derived and change only at the clock edge following the handshake.
- o_push_ready and o_pop_valid depend only on registered state. There is no combinational path from i_pop_ready to o_push_ready.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- KEY_QUEUE_REPLACE_EN defined:
  - o_push_ready is tied to 1.
  - Push while full and no pop: the record overwrites the oldest entry. wr_ptr and rd_ptr both advance; count stays DEPTH.
  - o_drop pulses in the cycle after that edge, and o_drop_cnt increments, saturating at 16'hFFFF.
  - Push and pop while full: a normal exchange; no drop is recorded.
- KEY_QUEUE_REPLACE_EN undefined:
  - o_push_ready = !o_full, so a push while full is refused even if a pop fires in the same cycle.
  - o_drop and o_drop_cnt are tied to 0.

## Test plan
- Reset, then push (x=5, y=7, sin=12'h7FF, cos=12'h800), holding pop_ready=0 -> next cycle o_pop_valid=1, outputs 5/7/7FF/800, o_count=1. Then pop -> o_empty=1 and outputs 0.
- DEPTH=4: push records 1..4 -> o_full=1, o_push_ready=0 (macro off). Then pop all -> outputs in order 1,2,3,4.
- DEPTH=3: run 10 interleaved push/pop cycles with continuous streaming -> pointer wrap gives in-order data and count steady at 1.
- Macro on, DEPTH=4: push 1..6 without popping -> o_drop pulses twice, o_drop_cnt=2, head=3, count=4.
- Full queue with push, pop and flush asserted in one cycle -> next cycle count=0, o_empty=1, no record delivered.
- Assert i_rst asynchronously mid-stream with count=2 -> all outputs return to their reset values before the next clock edge.

Source files
------------

// File: rtl/key_queue_if.sv
// Keypoint queue handshake bundle: push side, pop side and status.
// Zero latency; only carries the valid/ready pairs and status.
interface key_queue_if #(
    parameter int DEPTH = 100,
    parameter int CW    = 10,
    parameter int TW    = 12
);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic            i_flush;
    logic            i_push_valid;
    logic            o_push_ready;
    logic [CW-1:0]   i_coor_x;
    logic [CW-1:0]   i_coor_y;
    logic [TW-1:0]   i_sin;
    logic [TW-1:0]   i_cos;
    logic            o_pop_valid;
    logic            i_pop_ready;
    logic [CW-1:0]   o_coor_x;
    logic [CW-1:0]   o_coor_y;
    logic [TW-1:0]   o_sin;
    logic [TW-1:0]   o_cos;
    logic [CNTW-1:0] o_count;
    logic            o_full;
    logic            o_empty;
    logic            o_drop;
    logic [15:0]     o_drop_cnt;

    modport slave (
        input  i_flush, i_push_valid, i_coor_x, i_coor_y, i_sin, i_cos, i_pop_ready,
        output o_push_ready, o_pop_valid, o_coor_x, o_coor_y, o_sin, o_cos,
               o_count, o_full, o_empty, o_drop, o_drop_cnt
    );

    modport master (
        output i_flush, i_push_valid, i_coor_x, i_coor_y, i_sin, i_cos, i_pop_ready,
        input  o_push_ready, o_pop_valid, o_coor_x, o_coor_y, o_sin, o_cos,
               o_count, o_full, o_empty, o_drop, o_drop_cnt
    );
endinterface

// File: rtl/key_queue.sv
// Circular keypoint FIFO (FWFT); KEY_QUEUE_REPLACE_EN overwrites the oldest entry when full.
// Push-to-head latency 1 cycle; back-pressures on full unless replace mode is built in.
module key_queue #(
    parameter int DEPTH = 100,
    parameter int CW    = 10,
    parameter int TW    = 12
) (
    input  logic      i_clk,
    input  logic      i_rst,
    key_queue_if.slave q
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [TW-1:0] s;
        logic [TW-1:0] c;
    } rec_t;

    rec_t            mem [DEPTH];
    rec_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            full;
    logic            empty;
    logic            push_ready;
    logic            push_fire;
    logic            pop_fire;
    logic            overwrite;

    // Pointers wrap at DEPTH-1 so non power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CNTW'(DEPTH));
    assign empty = (count == '0);

`ifdef KEY_QUEUE_REPLACE_EN
    assign push_ready = 1'b1;
    assign overwrite  = push_fire && full && !pop_fire;
`else
    assign push_ready = !full;
    assign overwrite  = 1'b0;
`endif

    assign push_fire = q.i_push_valid && push_ready;
    assign pop_fire  = !empty && q.i_pop_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_fire || overwrite)
                rd_ptr <= ptr_inc(rd_ptr);
            // An overwrite retires one entry and adds one, so occupancy holds.
            case ({push_fire && !overwrite, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_fire && !q.i_flush && !i_rst)
            mem[wr_ptr] <= '{x: q.i_coor_x, y: q.i_coor_y, s: q.i_sin, c: q.i_cos};
    end

`ifdef KEY_QUEUE_REPLACE_EN
    logic        drop;
    logic [15:0] drop_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drop     <= 1'b0;
            drop_cnt <= '0;
        end else if (q.i_flush) begin
            drop     <= 1'b0;
        end else begin
            drop <= overwrite;
            if (overwrite && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign q.o_drop     = drop;
    assign q.o_drop_cnt = drop_cnt;
`else
    assign q.o_drop     = 1'b0;
    assign q.o_drop_cnt = 16'd0;
`endif

    // Unwritten memory may hold anything, so the head is masked while empty.
    assign head = empty ? '0 : mem[rd_ptr];

    assign q.o_push_ready = push_ready;
    assign q.o_pop_valid  = !empty;
    assign q.o_coor_x     = head.x;
    assign q.o_coor_y     = head.y;
    assign q.o_sin        = head.s;
    assign q.o_cos        = head.c;
    assign q.o_count      = count;
    assign q.o_full       = full;
    assign q.o_empty      = empty;
endmodule

// File: tb/tb_key_queue.sv
// Bench for key_queue: two instances (DEPTH 4 and 3) share stimulus and are
// compared every cycle against list-based reference queues.
module tb_key_queue;
    localparam int CW = 10;
    localparam int TW = 12;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic [TW-1:0] s;
        logic [TW-1:0] c;
    } rec_t;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 i_clk = ~i_clk;

    key_queue_if #(.DEPTH(4), .CW(CW), .TW(TW)) qa ();
    key_queue_if #(.DEPTH(3), .CW(CW), .TW(TW)) qb ();

    key_queue #(.DEPTH(4), .CW(CW), .TW(TW)) u4 (.i_clk(i_clk), .i_rst(i_rst), .q(qa));
    key_queue #(.DEPTH(3), .CW(CW), .TW(TW)) u3 (.i_clk(i_clk), .i_rst(i_rst), .q(qb));

    // Reference: element 0 is the head; pops shift the list down.
    rec_t mq [2][8];
    int   mn [2];
    bit   mdrop [2];
    int   mdc [2];
    int   dep [2] = '{4, 3};
`ifdef KEY_QUEUE_REPLACE_EN
    localparam bit REPLACE = 1'b1;
`else
    localparam bit REPLACE = 1'b0;
`endif

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s dut%0d: got %0h expected %0h", name, k, act, exp);
    endtask

    task automatic shift_out(input int k);
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        mn[k]--;
    endtask

    task automatic model_step(input int k);
        bit   pr;
        bit   pushf;
        bit   popf;
        rec_t r;
        r     = rec_t'({qa.i_coor_x, qa.i_coor_y, qa.i_sin, qa.i_cos});
        pr    = REPLACE ? 1'b1 : (mn[k] != dep[k]);
        pushf = qa.i_push_valid && pr;
        popf  = (mn[k] != 0) && qa.i_pop_ready;
        mdrop[k] = 1'b0;
        if (qa.i_flush) begin
            mn[k] = 0;
        end else begin
            if (popf) shift_out(k);
            if (pushf) begin
                if (mn[k] == dep[k]) begin
                    shift_out(k);
                    mdrop[k] = 1'b1;
                    if (mdc[k] < 65535) mdc[k]++;
                end
                mq[k][mn[k]] = r;
                mn[k]++;
            end
        end
    endtask

    always @(posedge i_clk or posedge i_rst) begin
        for (int k = 0; k < 2; k++) begin
            if (i_rst) begin
                mn[k] = 0; mdrop[k] = 1'b0; mdc[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic cmp_dut(input int k, input logic pv, input logic pr, input logic fu,
                           input logic em, input int cnt, input rec_t d,
                           input logic dr, input logic [15:0] dc);
        rec_t e;
        e = (mn[k] != 0) ? mq[k][0] : '0;
        chk("pop_valid", k, 64'(pv), 64'(mn[k] != 0));
        chk("push_ready", k, 64'(pr), 64'(REPLACE || mn[k] != dep[k]));
        chk("full", k, 64'(fu), 64'(mn[k] == dep[k]));
        chk("empty", k, 64'(em), 64'(mn[k] == 0));
        chk("count", k, 64'(cnt), 64'(mn[k]));
        chk("head", k, 64'(d), 64'(e));
        chk("drop", k, 64'(dr), 64'(mdrop[k]));
        chk("drop_cnt", k, 64'(dc), 64'(mdc[k]));
    endtask

    always @(negedge i_clk) begin
        if (cmp_en && !i_rst) begin
            cmp_dut(0, qa.o_pop_valid, qa.o_push_ready, qa.o_full, qa.o_empty, int'(qa.o_count),
                    rec_t'({qa.o_coor_x, qa.o_coor_y, qa.o_sin, qa.o_cos}), qa.o_drop, qa.o_drop_cnt);
            cmp_dut(1, qb.o_pop_valid, qb.o_push_ready, qb.o_full, qb.o_empty, int'(qb.o_count),
                    rec_t'({qb.o_coor_x, qb.o_coor_y, qb.o_sin, qb.o_cos}), qb.o_drop, qb.o_drop_cnt);
        end
    end

    function automatic rec_t mk(input int v);
        rec_t r;
        r.x = CW'(v); r.y = CW'(v); r.s = TW'(v); r.c = TW'(v);
        return r;
    endfunction

    task automatic set_in(input logic pv, input logic pr, input logic fl, input rec_t r);
        qa.i_push_valid = pv; qa.i_pop_ready = pr; qa.i_flush = fl;
        qa.i_coor_x = r.x; qa.i_coor_y = r.y; qa.i_sin = r.s; qa.i_cos = r.c;
        qb.i_push_valid = pv; qb.i_pop_ready = pr; qb.i_flush = fl;
        qb.i_coor_x = r.x; qb.i_coor_y = r.y; qb.i_sin = r.s; qb.i_cos = r.c;
    endtask

    // Apply inputs for exactly one rising edge, then return to idle.
    task automatic cyc(input logic pv, input logic pr, input logic fl, input rec_t r);
        set_in(pv, pr, fl, r);
        @(posedge i_clk);
        #1;
        set_in(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_push_ready"}, 0, 64'(qa.o_push_ready), 64'd1);
        chk({tag, "_pop_valid"}, 0, 64'(qa.o_pop_valid), 64'd0);
        chk({tag, "_empty"}, 0, 64'(qa.o_empty), 64'd1);
        chk({tag, "_full"}, 0, 64'(qa.o_full), 64'd0);
        chk({tag, "_count"}, 0, 64'(qa.o_count), 64'd0);
        chk({tag, "_data"}, 0, 64'({qa.o_coor_x, qa.o_coor_y, qa.o_sin, qa.o_cos}), 64'd0);
        chk({tag, "_drop"}, 0, 64'(qa.o_drop), 64'd0);
        chk({tag, "_drop_cnt"}, 0, 64'(qa.o_drop_cnt), 64'd0);
    endtask

    initial begin
        rec_t r;
        int   ph;
        set_in(1'b0, 1'b0, 1'b0, '0);
        #2 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        chk_reset_vals("rst");
        i_rst  = 1'b0;
        cmp_en = 1'b1;

        // Single record through an empty queue.
        r = '{x: 10'd5, y: 10'd7, s: 12'h7FF, c: 12'h800};
        cyc(1'b1, 1'b0, 1'b0, r);
        @(negedge i_clk);
        chk("basic_valid", 0, 64'(qa.o_pop_valid), 64'd1);
        chk("basic_data", 0, 64'({qa.o_coor_x, qa.o_coor_y, qa.o_sin, qa.o_cos}),
            {20'd0, 10'd5, 10'd7, 12'h7FF, 12'h800});
        chk("basic_count", 0, 64'(qa.o_count), 64'd1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        @(negedge i_clk);
        chk("basic_empty", 0, 64'(qa.o_empty), 64'd1);
        chk("basic_zero", 0, 64'(qa.o_coor_x), 64'd0);

        // Fill DEPTH=4, then drain in order.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, mk(i));
        @(negedge i_clk);
        chk("fill_full", 0, 64'(qa.o_full), 64'd1);
        chk("fill_push_ready", 0, 64'(qa.o_push_ready), REPLACE ? 64'd1 : 64'd0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge i_clk);
            chk("drain_order", 0, 64'(qa.o_coor_x), 64'(i));
            cyc(1'b0, 1'b1, 1'b0, '0);
        end
        @(negedge i_clk);
        chk("drain_empty", 0, 64'(qa.o_empty), 64'd1);

`ifdef KEY_QUEUE_REPLACE_EN
        cyc(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, mk(i));
        @(negedge i_clk);
        chk("repl_drop_cnt", 0, 64'(qa.o_drop_cnt), 64'd2);
        chk("repl_head", 0, 64'(qa.o_coor_x), 64'd3);
        chk("repl_count", 0, 64'(qa.o_count), 64'd4);
`endif

        // Full queue with push, pop and flush together.
        cyc(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, mk(i + 20));
        cyc(1'b1, 1'b1, 1'b1, mk(99));
        @(negedge i_clk);
        chk("flush_count", 0, 64'(qa.o_count), 64'd0);
        chk("flush_empty", 0, 64'(qa.o_empty), 64'd1);
        chk("flush_valid", 0, 64'(qa.o_pop_valid), 64'd0);

        // Streaming through DEPTH=3 with pointer wrap.
        cyc(1'b1, 1'b0, 1'b0, mk(100));
        for (int j = 1; j <= 10; j++) cyc(1'b1, 1'b1, 1'b0, mk(100 + j));
        @(negedge i_clk);
        chk("stream_count", 1, 64'(qb.o_count), 64'd1);
        chk("stream_head", 1, 64'(qb.o_coor_x), 64'd110);

        // Randomized traffic with phase-dependent bias to hit full and empty.
        for (int j = 0; j < 2400; j++) begin
            ph = (j / 200) % 3;
            r  = rec_t'({$urandom, $urandom});
            cyc((ph == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 63) == 0), r);
        end

        // Asynchronous reset between edges with two records queued.
        cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 1'b0, mk(7));
        cyc(1'b1, 1'b0, 1'b0, mk(8));
        @(negedge i_clk);
        chk("arst_pre_count", 0, 64'(qa.o_count), 64'd2);
        #2 i_rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("arst_post_empty", 0, 64'(qa.o_empty), 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
